signdet_score_argmax: RTL and testbench



---
 rtl/signdet_score_argmax.sv | 107 ++++++++++
 tb/tb_signdet_score_argmax.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/signdet_score_argmax.sv
// rtl/signdet_score_argmax.sv - streaming top-2 search over per-class CNN scores
// Emits the winning class index and the saturated best-minus-second margin per frame.
module signdet_score_argmax #(
  parameter int N_CLASS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_frame_start,
  input  logic [15:0] i_score,
  input  logic        i_score_vld,
  output logic [4:0]  o_max_idx,
  output logic [15:0] o_diff,
  output logic        o_validp,
  output logic        o_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  localparam logic [4:0] LAST_IDX = 5'(N_CLASS - 1);
  localparam logic signed [15:0] MIN_SCORE = 16'sh8000;

  state_t             state_q;
  logic signed [15:0] best_q;
  logic signed [15:0] second_q;
  logic [4:0]         best_idx_q;
  logic [4:0]         cnt_q;

  logic               start;
  logic signed [15:0] score_s;
  logic signed [17:0] margin;
  logic [15:0]        diff_d;

  assign start   = i_score_vld & i_frame_start;
  assign score_s = i_score;

  // Widened subtraction so the full 16-bit signed span cannot overflow.
  assign margin = {{2{best_q[15]}}, best_q} - {{2{second_q[15]}}, second_q};
  assign diff_d = (margin > 18'sd65535) ? 16'hFFFF : margin[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      best_q     <= '0;
      second_q   <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      o_max_idx  <= 5'd9;
      o_diff     <= '0;
      o_validp   <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_validp <= 1'b0;
      o_err    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            best_q     <= score_s;
            best_idx_q <= '0;
            second_q   <= MIN_SCORE;
            cnt_q      <= 5'd1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (start) begin
            // Abandon the partial frame; the marked score restarts at class 0.
            o_err      <= 1'b1;
            best_q     <= score_s;
            best_idx_q <= '0;
            second_q   <= MIN_SCORE;
            cnt_q      <= 5'd1;
          end else if (i_score_vld) begin
            if (score_s > best_q) begin
              second_q   <= best_q;
              best_q     <= score_s;
              best_idx_q <= cnt_q;
            end else if (score_s > second_q) begin
              second_q <= score_s;
            end
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LAST_IDX) begin
              state_q <= EMIT;
            end
          end
        end
        EMIT: begin
          o_max_idx <= best_idx_q;
          o_diff    <= diff_d;
          o_validp  <= 1'b1;
          if (start) begin
            o_err      <= 1'b1;
            best_q     <= score_s;
            best_idx_q <= '0;
            second_q   <= MIN_SCORE;
            cnt_q      <= 5'd1;
            state_q    <= ACCUM;
          end else begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signdet_score_argmax.sv
// tb/tb_signdet_score_argmax.sv - table-driven bench for signdet_score_argmax
// Directed frames with hand-computed winners and margins, plus abort/collision/reset sequences.
module tb_signdet_score_argmax;

  logic        clk;
  logic        reset;
  logic        fs;
  logic [15:0] score;
  logic        vld;
  logic [4:0]  o_max_idx;
  logic [15:0] o_diff;
  logic        o_validp;
  logic        o_err;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int last_acc = 0;

  int vp_cyc_q[$];
  int vp_idx_q[$];
  int vp_diff_q[$];
  int err_cyc_q[$];

  typedef struct {
    logic [9:0][15:0] s;
    bit               gapped;
    int               exp_idx;
    int               exp_diff;
  } vec_t;

  vec_t vecs[4];

  signdet_score_argmax #(.N_CLASS(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_frame_start(fs),
    .i_score      (score),
    .i_score_vld  (vld),
    .o_max_idx    (o_max_idx),
    .o_diff       (o_diff),
    .o_validp     (o_validp),
    .o_err        (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pulses recorded with the number of the edge that registered them.
  always @(negedge clk) begin
    if (o_validp) begin
      vp_cyc_q.push_back(cyc);
      vp_idx_q.push_back(int'(o_max_idx));
      vp_diff_q.push_back(int'(o_diff));
    end
    if (o_err) err_cyc_q.push_back(cyc);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] s, input logic st, input int gap);
    fs    = st;
    vld   = 1'b1;
    score = s;
    tick();
    last_acc = cyc;
    vld = 1'b0;
    fs  = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  initial begin
    int n0;
    int e0;
    logic [9:0][15:0] fa;
    logic [9:0][15:0] fb;

    for (int i = 0; i < 10; i++) begin
      vecs[0].s[i] = 16'(i * 10);
      vecs[1].s[i] = 16'hFFFB;
      vecs[2].s[i] = 16'h8000;
      vecs[3].s[i] = 16'h0000;
    end
    vecs[0].gapped = 1'b0; vecs[0].exp_idx = 9; vecs[0].exp_diff = 10;
    vecs[1].s[3] = 16'h1200; vecs[1].s[7] = 16'h0200;
    vecs[1].gapped = 1'b1; vecs[1].exp_idx = 3; vecs[1].exp_diff = 16'h1000;
    vecs[2].s[0] = 16'h7FFF;
    vecs[2].gapped = 1'b0; vecs[2].exp_idx = 0; vecs[2].exp_diff = 16'hFFFF;
    vecs[3].s[2] = 16'd100; vecs[3].s[5] = 16'd100;
    vecs[3].gapped = 1'b0; vecs[3].exp_idx = 2; vecs[3].exp_diff = 0;

    reset = 1'b1; fs = 1'b0; vld = 1'b0; score = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_idx", int'(o_max_idx), 9);
    chk("reset_diff", int'(o_diff), 0);
    chk("reset_validp", int'(o_validp), 0);
    chk("reset_err", int'(o_err), 0);

    // Unmarked scores in IDLE must be dropped silently.
    for (int i = 0; i < 12; i++) drive(16'(i * 7), 1'b0, 0);
    repeat (4) tick();
    chk("idle_drop_pulses", vp_cyc_q.size() + err_cyc_q.size(), 0);
    chk("idle_hold_idx", int'(o_max_idx), 9);
    chk("idle_hold_diff", int'(o_diff), 0);

    for (int v = 0; v < 4; v++) begin
      n0 = vp_cyc_q.size();
      e0 = err_cyc_q.size();
      for (int i = 0; i < 10; i++)
        drive(vecs[v].s[i], i == 0, (vecs[v].gapped && i < 9) ? 1 + (i % 3) : 0);
      repeat (6) tick();
      chk($sformatf("vec%0d_pulses", v), vp_cyc_q.size() - n0, 1);
      chk($sformatf("vec%0d_err", v), err_cyc_q.size() - e0, 0);
      if (vp_cyc_q.size() > n0) begin
        chk($sformatf("vec%0d_idx", v), vp_idx_q[n0], vecs[v].exp_idx);
        chk($sformatf("vec%0d_diff", v), vp_diff_q[n0], vecs[v].exp_diff);
        // Pulse is first seen high when sampled at the second edge after acceptance.
        chk($sformatf("vec%0d_latency", v), vp_cyc_q[n0] + 1 - last_acc, 2);
      end
    end

    // Abort after 4 scores, then a full frame won by class 1.
    n0 = vp_cyc_q.size();
    e0 = err_cyc_q.size();
    for (int i = 0; i < 4; i++) drive(16'd500, i == 0, 0);
    for (int i = 0; i < 10; i++)
      drive((i == 1) ? 16'd300 : (i == 0) ? 16'd20 : 16'd0, i == 0, 0);
    repeat (6) tick();
    chk("abort_err", err_cyc_q.size() - e0, 1);
    chk("abort_pulses", vp_cyc_q.size() - n0, 1);
    if (vp_cyc_q.size() > n0) begin
      chk("abort_idx", vp_idx_q[n0], 1);
      chk("abort_diff", vp_diff_q[n0], 280);
    end

    // Back-to-back: B's start lands in A's EMIT cycle.
    for (int i = 0; i < 10; i++) begin
      fa[i] = 16'd0;
      fb[i] = 16'hFFFF;
    end
    fa[4] = 16'd1000;
    fb[6] = 16'd700;
    fb[1] = 16'd650;
    n0 = vp_cyc_q.size();
    e0 = err_cyc_q.size();
    for (int i = 0; i < 10; i++) drive(fa[i], i == 0, 0);
    for (int i = 0; i < 10; i++) drive(fb[i], i == 0, 0);
    repeat (6) tick();
    chk("b2b_pulses", vp_cyc_q.size() - n0, 2);
    chk("b2b_err", err_cyc_q.size() - e0, 1);
    if (vp_cyc_q.size() >= n0 + 2 && err_cyc_q.size() > e0) begin
      chk("b2b_a_idx", vp_idx_q[n0], 4);
      chk("b2b_a_diff", vp_diff_q[n0], 1000);
      chk("b2b_b_idx", vp_idx_q[n0 + 1], 6);
      chk("b2b_b_diff", vp_diff_q[n0 + 1], 50);
      chk("b2b_period", vp_cyc_q[n0 + 1] - vp_cyc_q[n0], 10);
      chk("b2b_err_with_a", err_cyc_q[e0], vp_cyc_q[n0]);
    end

    // Reset mid-frame discards the partial frame.
    n0 = vp_cyc_q.size();
    e0 = err_cyc_q.size();
    for (int i = 0; i < 5; i++) drive(16'(i * 3), i == 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) drive(16'd9, 1'b0, 0);
    repeat (12) tick();
    chk("rst_mid_pulses", vp_cyc_q.size() - n0, 0);
    chk("rst_mid_err", err_cyc_q.size() - e0, 0);
    chk("rst_mid_idx", int'(o_max_idx), 9);
    chk("rst_mid_diff", int'(o_diff), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
